// File: rtl/ssd_pkg.sv
// Shared seven-segment definitions: active-low digit patterns and scan-mux state encoding.
// Bit 6 is segment a, bit 0 is segment g; a 0 lights the segment.
package ssd_pkg;

   localparam int SEG_W = 7;

   localparam logic [SEG_W-1:0] SEG_BLANK = 7'b1111111;

   localparam logic [SEG_W-1:0] SEG_0 = 7'b0000001;
   localparam logic [SEG_W-1:0] SEG_1 = 7'b1001111;
   localparam logic [SEG_W-1:0] SEG_2 = 7'b0010010;
   localparam logic [SEG_W-1:0] SEG_3 = 7'b0000110;
   localparam logic [SEG_W-1:0] SEG_4 = 7'b1001100;
   localparam logic [SEG_W-1:0] SEG_5 = 7'b0100100;
   localparam logic [SEG_W-1:0] SEG_6 = 7'b0100000;
   localparam logic [SEG_W-1:0] SEG_7 = 7'b0001111;
   localparam logic [SEG_W-1:0] SEG_8 = 7'b0000000;
   localparam logic [SEG_W-1:0] SEG_9 = 7'b0000100;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BLANK = 2'd1,
      DRIVE = 2'd2
   } scan_state_t;

   // Decimal digit to pattern; anything above 9 shows as dark.
   function automatic logic [SEG_W-1:0] seg_digit(input logic [3:0] d);
      case (d)
         4'd0:    return SEG_0;
         4'd1:    return SEG_1;
         4'd2:    return SEG_2;
         4'd3:    return SEG_3;
         4'd4:    return SEG_4;
         4'd5:    return SEG_5;
         4'd6:    return SEG_6;
         4'd7:    return SEG_7;
         4'd8:    return SEG_8;
         4'd9:    return SEG_9;
         default: return SEG_BLANK;
      endcase
   endfunction

endpackage

// File: rtl/ssd_tick_gen.sv
// Modulo-TICKS slot counter for the scan mux, with synchronous clear and
// decoded end-of-slot / end-of-blanking flags.
module ssd_tick_gen #(
   parameter int TICKS       = 50000,
   parameter int BLANK_TICKS = 500,
   localparam int TW         = $clog2(TICKS)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          clear,
   output logic [TW-1:0] tick,
   output logic          slot_end,
   output logic          blank_end
);

   assign slot_end = (tick == TW'(TICKS - 1));

   generate
      if (BLANK_TICKS == 0) begin : g_no_blank
         assign blank_end = 1'b0;
      end else begin : g_blank
         assign blank_end = (tick == TW'(BLANK_TICKS - 1));
      end
   endgenerate

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tick <= '0;
      end else if (clear || slot_end) begin
         tick <= '0;
      end else begin
         tick <= tick + TW'(1);
      end
   end

endmodule

// File: rtl/ssd_scan_mux.sv
// Time-multiplexes NUM_DIGITS active-low seven-segment patterns onto one shared
// bus, with per-frame input snapshots and a blanking gap at the start of every slot.
module ssd_scan_mux
   import ssd_pkg::*;
#(
   parameter int NUM_DIGITS      = 6,
   parameter int TICKS_PER_DIGIT = 50000,
   parameter int BLANK_TICKS     = 500
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        en,
   input  logic [SEG_W*NUM_DIGITS-1:0] ssd_in,
   input  logic [NUM_DIGITS-1:0]       dp_in,
   output logic [SEG_W-1:0]            seg_out,
   output logic                        dp_out,
   output logic [NUM_DIGITS-1:0]       an_out,
   output logic                        frame_done
);

   localparam int TW = $clog2(TICKS_PER_DIGIT);
   localparam int IW = $clog2(NUM_DIGITS);
   localparam scan_state_t SLOT_START = (BLANK_TICKS == 0) ? DRIVE : BLANK;

   scan_state_t state, state_nxt;
   logic [IW-1:0] idx, idx_nxt;
   logic          take_snap;
   logic          last_digit;

   logic [NUM_DIGITS-1:0][SEG_W-1:0] snap_seg;
   logic [NUM_DIGITS-1:0]            snap_dp;

   logic [TW-1:0] tick;
   logic          slot_end;
   logic          blank_end;
   logic          tick_clear;
   logic          in_blank;

   logic [SEG_W-1:0]      seg_nxt;
   logic                  dp_nxt;
   logic [NUM_DIGITS-1:0] an_nxt;
   logic                  frame_nxt;

   assign tick_clear = !en || (state == IDLE);
   assign last_digit = (idx == IW'(NUM_DIGITS - 1));

   ssd_tick_gen #(
      .TICKS       (TICKS_PER_DIGIT),
      .BLANK_TICKS (BLANK_TICKS)
   ) u_tick_gen (
      .clk       (clk),
      .rst_n     (rst_n),
      .clear     (tick_clear),
      .tick      (tick),
      .slot_end  (slot_end),
      .blank_end (blank_end)
   );

   // Interlock: an anode is never enabled inside the blanking window of a slot.
   generate
      if (BLANK_TICKS == 0) begin : g_no_blank
         assign in_blank = 1'b0;
      end else begin : g_blank
         assign in_blank = (tick < TW'(BLANK_TICKS));
      end
   endgenerate

   always_comb begin
      // NOTE: every combinational output gets a default first so no path can infer a latch.
      state_nxt = state;
      idx_nxt   = idx;
      take_snap = 1'b0;
      if (!en) begin
         state_nxt = IDLE;
         idx_nxt   = '0;
      end else begin
         case (state)
            IDLE: begin
               state_nxt = SLOT_START;
               idx_nxt   = '0;
               take_snap = 1'b1;
            end
            BLANK: begin
               if (blank_end) state_nxt = DRIVE;
            end
            DRIVE: begin
               if (slot_end) begin
                  state_nxt = SLOT_START;
                  if (last_digit) begin
                     idx_nxt   = '0;
                     take_snap = 1'b1;
                  end else begin
                     idx_nxt = idx + IW'(1);
                  end
               end
            end
            default: begin
               state_nxt = IDLE;
               idx_nxt   = '0;
            end
         endcase
      end
   end

   always_comb begin
      seg_nxt   = SEG_BLANK;
      dp_nxt    = 1'b1;
      an_nxt    = '1;
      frame_nxt = en && (state == DRIVE) && slot_end && last_digit;
      if ((state == DRIVE) && !in_blank) begin
         seg_nxt     = snap_seg[idx];
         dp_nxt      = snap_dp[idx];
         an_nxt[idx] = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         idx   <= '0;
      end else begin
         state <= state_nxt;
         idx   <= idx_nxt;
      end
   end

   // NOTE: the snapshot is a handful of flops, so it is reset to dark rather than left undefined.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         snap_seg <= {NUM_DIGITS{SEG_BLANK}};
         snap_dp  <= '1;
      end else if (take_snap) begin
         snap_seg <= ssd_in;
         snap_dp  <= dp_in;
      end
   end

   // Output flops reset asynchronously to dark so a mid-slot reset cannot glitch an anode on.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         seg_out    <= SEG_BLANK;
         dp_out     <= 1'b1;
         an_out     <= '1;
         frame_done <= 1'b0;
      end else begin
         seg_out    <= seg_nxt;
         dp_out     <= dp_nxt;
         an_out     <= an_nxt;
         frame_done <= frame_nxt;
      end
   end

endmodule

// File: tb/tb_ssd_scan_mux.sv
// Self-checking bench: two scan muxes (2-tick and zero blanking) driven in parallel,
// compared every cycle against a frame-position model plus literal spot checks.
module tb_ssd_scan_mux;
   import ssd_pkg::*;

   localparam int N = 6;
   localparam int T = 8;
   localparam int F = N * T;

   logic          clk;
   logic          rst_n;
   logic          en;
   logic [41:0]   ssd_in;
   logic [5:0]    dp_in;

   logic [6:0] seg_a, seg_b;
   logic       dp_a, dp_b;
   logic [5:0] an_a, an_b;
   logic       fd_a, fd_b;

   int checks = 0;
   int errors = 0;

   ssd_scan_mux #(.NUM_DIGITS(N), .TICKS_PER_DIGIT(T), .BLANK_TICKS(2)) dut_a (
      .clk(clk), .rst_n(rst_n), .en(en), .ssd_in(ssd_in), .dp_in(dp_in),
      .seg_out(seg_a), .dp_out(dp_a), .an_out(an_a), .frame_done(fd_a)
   );

   ssd_scan_mux #(.NUM_DIGITS(N), .TICKS_PER_DIGIT(T), .BLANK_TICKS(0)) dut_b (
      .clk(clk), .rst_n(rst_n), .en(en), .ssd_in(ssd_in), .dp_in(dp_in),
      .seg_out(seg_b), .dp_out(dp_b), .an_out(an_b), .frame_done(fd_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Model: pos counts running cycles since enable; slot, offset and frame follow by division.
   int         blank_of[2] = '{2, 0};
   bit         act[2];
   int         pos[2];
   logic [6:0] msnap[2][N];
   logic       mdp[2][N];
   logic [5:0] e_an[2]  = '{6'h3F, 6'h3F};
   logic [6:0] e_seg[2] = '{7'h7F, 7'h7F};
   logic       e_dp[2]  = '{1'b1, 1'b1};
   logic       e_fd[2]  = '{1'b0, 1'b0};

   always @(posedge clk or negedge rst_n) begin
      for (int d = 0; d < 2; d++) begin
         if (!rst_n) begin
            act[d] = 1'b0; pos[d] = 0;
            e_an[d] = 6'h3F; e_seg[d] = 7'h7F; e_dp[d] = 1'b1; e_fd[d] = 1'b0;
         end else begin
            e_an[d] = 6'h3F; e_seg[d] = 7'h7F; e_dp[d] = 1'b1;
            if (act[d] && (pos[d] % T) >= blank_of[d]) begin
               e_an[d][(pos[d] % F) / T] = 1'b0;
               e_seg[d] = msnap[d][(pos[d] % F) / T];
               e_dp[d]  = mdp[d][(pos[d] % F) / T];
            end
            e_fd[d] = act[d] && en && ((pos[d] % F) == F - 1);
            if (!en) begin
               act[d] = 1'b0;
            end else begin
               if (!act[d]) begin
                  act[d] = 1'b1; pos[d] = 0;
               end else begin
                  pos[d]++;
               end
               if ((pos[d] % F) == 0) begin
                  for (int i = 0; i < N; i++) begin
                     msnap[d][i] = ssd_in[7*i +: 7];
                     mdp[d][i]   = dp_in[i];
                  end
               end
            end
         end
      end
   end

   always @(negedge clk) begin
      check("a_an",  an_a,  e_an[0]);
      check("a_seg", seg_a, e_seg[0]);
      check("a_dp",  dp_a,  e_dp[0]);
      check("a_fd",  fd_a,  e_fd[0]);
      check("b_an",  an_b,  e_an[1]);
      check("b_seg", seg_b, e_seg[1]);
      check("b_dp",  dp_b,  e_dp[1]);
      check("b_fd",  fd_b,  e_fd[1]);
   end

   initial begin
      rst_n = 1'b1; en = 1'b0; ssd_in = '1; dp_in = '1;
      #1 rst_n = 1'b0;

      // Reset held while inputs wiggle.
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         en     = ~en;
         ssd_in = 42'({$urandom, $urandom});
         dp_in  = 6'($urandom);
      end
      @(negedge clk);
      check("rst_an",  an_a, 6'b111111);
      check("rst_seg", seg_a, 7'h7F);
      check("rst_fd",  fd_a, 1'b0);
      rst_n = 1'b1; en = 1'b0;
      cyc(4);
      check("rel_an",  an_a, 6'b111111);
      check("rel_seg", seg_a, 7'h7F);

      // Basic scan: digit i shows i, only digit 0 has its point lit.
      for (int i = 0; i < N; i++) ssd_in[7*i +: 7] = seg_digit(4'(i));
      dp_in = 6'b111110;
      en = 1'b1;
      cyc(2);
      check("scan_blank_an", an_a, 6'b111111);
      check("nb_first_an",   an_b, 6'b111110);
      cyc(2);
      check("scan_d0_an",  an_a, 6'b111110);
      check("scan_d0_seg", seg_a, 7'b0000001);
      check("scan_d0_dp",  dp_a, 1'b0);
      cyc(6);
      check("scan_gap_an", an_a, 6'b111111);
      check("nb_d1_an",    an_b, 6'b111101);
      cyc(2);
      check("scan_d1_an",  an_a, 6'b111101);
      check("scan_d1_seg", seg_a, 7'b1001111);
      check("scan_d1_dp",  dp_a, 1'b1);
      cyc(36);
      check("fd_before", fd_a, 1'b0);
      cyc(1);
      check("fd_48_a", fd_a, 1'b1);
      check("fd_48_b", fd_b, 1'b1);
      cyc(1);
      check("fd_after", fd_a, 1'b0);

      // Snapshot coherence: change digits 0 and 5 during slot 3 of frame 2.
      cyc(26);
      ssd_in[0 +: 7]  = SEG_9;
      ssd_in[35 +: 7] = SEG_9;
      cyc(18);
      check("coh_d5_an",  an_a, 6'b011111);
      check("coh_d5_seg", seg_a, SEG_5);
      cyc(7);
      check("coh_new_an",  an_a, 6'b111110);
      check("coh_new_seg", seg_a, 7'b0000100);

      // Mid-frame disable during slot 2 DRIVE, then restart.
      cyc(15);
      en = 1'b0;
      cyc(2);
      check("dis_an_a",  an_a, 6'b111111);
      check("dis_seg_a", seg_a, 7'h7F);
      check("dis_an_b",  an_b, 6'b111111);
      cyc(5);
      en = 1'b1;
      cyc(2);
      check("re_blank_an", an_a, 6'b111111);
      check("re_nb_an",    an_b, 6'b111110);
      cyc(2);
      check("re_d0_an",  an_a, 6'b111110);
      check("re_d0_seg", seg_a, SEG_9);

      // Asynchronous reset pulse between clock edges while driving.
      #2 rst_n = 1'b0;
      #1;
      check("arst_an_a",  an_a, 6'b111111);
      check("arst_seg_a", seg_a, 7'h7F);
      check("arst_an_b",  an_b, 6'b111111);
      #1 rst_n = 1'b1;
      cyc(1);
      check("arst_idle_an", an_a, 6'b111111);
      cyc(3);
      check("arst_re_an_a", an_a, 6'b111110);
      check("arst_re_an_b", an_b, 6'b111110);

      // Zero-blank instance keeps exactly one anode on every cycle.
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         check("nb_onehot", $countones(~an_b), 1);
      end

      cyc(2);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
